// File: rtl/uart_axil_poller.sv
// AXI-Lite initiator that polls a UART status register and moves bytes between
// user AXI-Stream ports and the UART data register. Optional: UART_POLLER_TIMEOUT_EN.
module uart_axil_poller #(
  parameter int                  AXI_ALEN  = 32,
  parameter int                  AXI_DLEN  = 32,
  parameter int                  AXI_SLEN  = AXI_DLEN / 8,
  parameter int                  UART_DLEN = 8,
  parameter logic [AXI_ALEN-1:0] UART_ADDR = 32'h0,
  parameter int                  POLL_GAP  = 4,
  parameter int                  TIMEOUT   = 256
) (
  input  logic                 clk,
  input  logic                 rstn,
  output logic                 o_axi_awvalid,
  input  logic                 i_axi_awready,
  output logic [AXI_ALEN-1:0]  o_axi_awaddr,
  output logic                 o_axi_wvalid,
  input  logic                 i_axi_wready,
  output logic [AXI_DLEN-1:0]  o_axi_wdata,
  output logic [AXI_SLEN-1:0]  o_axi_wstrb,
  input  logic                 i_axi_bvalid,
  output logic                 o_axi_bready,
  input  logic [1:0]           i_axi_bresp,
  output logic                 o_axi_arvalid,
  input  logic                 i_axi_arready,
  output logic [AXI_ALEN-1:0]  o_axi_araddr,
  input  logic                 i_axi_rvalid,
  output logic                 o_axi_rready,
  input  logic [AXI_DLEN-1:0]  i_axi_rdata,
  input  logic [1:0]           i_axi_rresp,
  input  logic                 i_tx_tvalid,
  output logic                 o_tx_tready,
  input  logic [UART_DLEN-1:0] i_tx_tdata,
  output logic                 o_rx_tvalid,
  input  logic                 i_rx_tready,
  output logic [UART_DLEN-1:0] o_rx_tdata,
  output logic                 o_err,
  output logic [1:0]           o_err_resp
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_POLL_AR = 3'd1;
  localparam logic [2:0] S_POLL_R  = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_WR_B    = 3'd4;
  localparam logic [2:0] S_RD_AR   = 3'd5;
  localparam logic [2:0] S_RD_R    = 3'd6;
  localparam logic [2:0] S_GAP     = 3'd7;

  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  logic [2:0]           r_state;
  logic [GW-1:0]        r_gap_cnt;
  logic                 r_awvalid;
  logic [AXI_ALEN-1:0]  r_awaddr;
  logic                 r_wvalid;
  logic [AXI_DLEN-1:0]  r_wdata;
  logic [AXI_SLEN-1:0]  r_wstrb;
  logic                 r_bready;
  logic                 r_arvalid;
  logic [AXI_ALEN-1:0]  r_araddr;
  logic                 r_rready;
  logic                 r_tx_tready;
  logic                 r_rx_tvalid;
  logic [UART_DLEN-1:0] r_rx_tdata;
  logic                 r_err;
  logic [1:0]           r_err_resp;

  logic w_aw_done;
  logic w_w_done;
  logic w_unused;

  // A write channel is finished once its valid is low or is being accepted now.
  assign w_aw_done = !r_awvalid || i_axi_awready;
  assign w_w_done  = !r_wvalid  || i_axi_wready;
  assign w_unused  = ^i_axi_rdata;

`ifdef UART_POLLER_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] r_to_cnt;
  logic          w_wait;
  logic          w_hs;

  assign w_wait = (r_state != S_IDLE) && (r_state != S_GAP);

  // Handshake that lets the current waiting state advance this cycle.
  always_comb begin
    w_hs = 1'b0;
    case (r_state)
      S_POLL_AR, S_RD_AR: w_hs = i_axi_arready;
      S_POLL_R, S_RD_R:   w_hs = i_axi_rvalid;
      S_WR:               w_hs = w_aw_done && w_w_done;
      S_WR_B:             w_hs = i_axi_bvalid;
      default:            w_hs = 1'b0;
    endcase
  end
`else
  logic [31:0] w_unused_to;
  assign w_unused_to = TIMEOUT;
`endif

  // Poller FSM with all AXI and stream outputs held in registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_gap_cnt   <= '0;
      r_awvalid   <= 1'b0;
      r_awaddr    <= '0;
      r_wvalid    <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      r_rready    <= 1'b0;
      r_tx_tready <= 1'b0;
      r_rx_tvalid <= 1'b0;
      r_rx_tdata  <= '0;
      r_err       <= 1'b0;
      r_err_resp  <= 2'b00;
`ifdef UART_POLLER_TIMEOUT_EN
      r_to_cnt    <= '0;
`endif
    end else begin
      r_tx_tready <= 1'b0;
      if (r_rx_tvalid && i_rx_tready) begin
        r_rx_tvalid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_arvalid <= 1'b1;
          r_araddr  <= UART_ADDR + AXI_ALEN'(1);
          r_state   <= S_POLL_AR;
        end
        S_POLL_AR: begin
          if (i_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_POLL_R;
          end
        end
        S_POLL_R: begin
          if (i_axi_rvalid) begin
            r_rready <= 1'b0;
            // Status bits: [0] tx ready, [4] rx byte available; rx wins.
            if (i_axi_rresp != 2'b00) begin
              r_err      <= 1'b1;
              r_err_resp <= i_axi_rresp;
              r_gap_cnt  <= '0;
              r_state    <= S_GAP;
            end else if (i_axi_rdata[4] && !r_rx_tvalid) begin
              r_arvalid <= 1'b1;
              r_araddr  <= UART_ADDR;
              r_state   <= S_RD_AR;
            end else if (i_axi_rdata[0] && i_tx_tvalid) begin
              r_tx_tready <= 1'b1;
              r_awvalid   <= 1'b1;
              r_awaddr    <= UART_ADDR;
              r_wvalid    <= 1'b1;
              r_wdata     <= {{(AXI_DLEN-UART_DLEN){1'b0}}, i_tx_tdata};
              r_wstrb     <= AXI_SLEN'(1);
              r_state     <= S_WR;
            end else begin
              r_gap_cnt <= '0;
              r_state   <= S_GAP;
            end
          end
        end
        S_WR: begin
          if (r_awvalid && i_axi_awready) begin
            r_awvalid <= 1'b0;
          end
          if (r_wvalid && i_axi_wready) begin
            r_wvalid <= 1'b0;
          end
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_B;
          end
        end
        S_WR_B: begin
          if (i_axi_bvalid) begin
            r_bready <= 1'b0;
            if (i_axi_bresp != 2'b00) begin
              r_err      <= 1'b1;
              r_err_resp <= i_axi_bresp;
            end
            r_state <= S_IDLE;
          end
        end
        S_RD_AR: begin
          if (i_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_R;
          end
        end
        S_RD_R: begin
          if (i_axi_rvalid) begin
            r_rready <= 1'b0;
            if (i_axi_rresp == 2'b00) begin
              r_rx_tdata  <= i_axi_rdata[UART_DLEN-1:0];
              r_rx_tvalid <= 1'b1;
            end else begin
              r_err      <= 1'b1;
              r_err_resp <= i_axi_rresp;
            end
            r_state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GW'(POLL_GAP - 1)) begin
            r_gap_cnt <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        default: begin
          r_awvalid <= 1'b0;
          r_wvalid  <= 1'b0;
          r_bready  <= 1'b0;
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase

`ifdef UART_POLLER_TIMEOUT_EN
      // Watchdog overrides the FSM: abandon the stalled handshake entirely.
      if (!w_wait || w_hs) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
        r_to_cnt    <= '0;
        r_awvalid   <= 1'b0;
        r_wvalid    <= 1'b0;
        r_bready    <= 1'b0;
        r_arvalid   <= 1'b0;
        r_rready    <= 1'b0;
        r_tx_tready <= 1'b0;
        r_err       <= 1'b1;
        r_err_resp  <= 2'b11;
        r_state     <= S_IDLE;
      end else begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end
`endif
    end
  end

  assign o_axi_awvalid = r_awvalid;
  assign o_axi_awaddr  = r_awaddr;
  assign o_axi_wvalid  = r_wvalid;
  assign o_axi_wdata   = r_wdata;
  assign o_axi_wstrb   = r_wstrb;
  assign o_axi_bready  = r_bready;
  assign o_axi_arvalid = r_arvalid;
  assign o_axi_araddr  = r_araddr;
  assign o_axi_rready  = r_rready;
  assign o_tx_tready   = r_tx_tready;
  assign o_rx_tvalid   = r_rx_tvalid;
  assign o_rx_tdata    = r_rx_tdata;
  assign o_err         = r_err;
  assign o_err_resp    = r_err_resp;

endmodule

// File: tb/tb_uart_axil_poller.sv
// Directed bench for uart_axil_poller: table of single-transaction vectors against
// a small AXI-Lite UART responder, plus hand-written multi-cycle sequences.
module tb_uart_axil_poller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        dut_awvalid, dut_wvalid, dut_bready, dut_arvalid, dut_rready;
  logic [31:0] dut_awaddr, dut_wdata, dut_araddr;
  logic [3:0]  dut_wstrb;
  logic        dut_tx_tready, dut_rx_tvalid, dut_err;
  logic [7:0]  dut_rx_tdata;
  logic [1:0]  dut_err_resp;

  logic        rsp_awready, rsp_wready, rsp_bvalid, rsp_arready, rsp_rvalid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_rresp;
  logic        tx_tvalid;

  // Responder / producer configuration, driven from the initial block.
  logic [31:0] status_val;
  logic        status_persist;
  logic [1:0]  status_rresp;
  logic [7:0]  data_byte;
  logic [1:0]  data_rresp;
  logic [1:0]  bresp_v;
  logic        tx_valid_req;
  logic [7:0]  tx_tdata;
  logic        rx_tready;
  logic        ar_block;
  int          aw_lag;

  // Monitor state.
  int          cyc = 0;
  int          n_star, n_dar, n_bad, n_aw, n_w, n_b, n_trdy, aw_alone, aw_wait, status_reads;
  int          viol = 0;
  int          ar_cyc [8];
  int          dar_cyc, aw_cyc;
  logic [31:0] last_wdata, last_awaddr;
  logic [3:0]  last_wstrb;
  logic        last_ar_status, tx_consumed, pend_ar, pend_aw, pend_w;

  int n_pass = 0;
  int n_tot  = 0;

  uart_axil_poller #(.POLL_GAP(4), .TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn),
    .o_axi_awvalid(dut_awvalid), .i_axi_awready(rsp_awready), .o_axi_awaddr(dut_awaddr),
    .o_axi_wvalid(dut_wvalid), .i_axi_wready(rsp_wready), .o_axi_wdata(dut_wdata),
    .o_axi_wstrb(dut_wstrb),
    .i_axi_bvalid(rsp_bvalid), .o_axi_bready(dut_bready), .i_axi_bresp(bresp_v),
    .o_axi_arvalid(dut_arvalid), .i_axi_arready(rsp_arready), .o_axi_araddr(dut_araddr),
    .i_axi_rvalid(rsp_rvalid), .o_axi_rready(dut_rready), .i_axi_rdata(rsp_rdata),
    .i_axi_rresp(rsp_rresp),
    .i_tx_tvalid(tx_tvalid), .o_tx_tready(dut_tx_tready), .i_tx_tdata(tx_tdata),
    .o_rx_tvalid(dut_rx_tvalid), .i_rx_tready(rx_tready), .o_rx_tdata(dut_rx_tdata),
    .o_err(dut_err), .o_err_resp(dut_err_resp)
  );

  // Zero-wait responder except for the configurable AW lag and AR block.
  assign rsp_arready = dut_arvalid && !ar_block;
  assign rsp_rvalid  = dut_rready;
  assign rsp_bvalid  = dut_bready;
  assign rsp_wready  = dut_wvalid;
  assign rsp_awready = dut_awvalid && (aw_wait >= aw_lag);
  assign rsp_rdata   = last_ar_status ? ((status_persist || status_reads == 0) ? status_val : 32'h0)
                                      : {24'h0, data_byte};
  assign rsp_rresp   = last_ar_status ? ((status_reads == 0) ? status_rresp : 2'b00) : data_rresp;
  assign tx_tvalid   = tx_valid_req && !tx_consumed;

  logic any_out;
  assign any_out = |{dut_awvalid, dut_awaddr, dut_wvalid, dut_wdata, dut_wstrb, dut_bready,
                     dut_arvalid, dut_araddr, dut_rready, dut_tx_tready, dut_rx_tvalid,
                     dut_rx_tdata, dut_err, dut_err_resp};

  // Bus monitor: counts handshakes and records when they happen.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rstn) begin
      n_star <= 0; n_dar <= 0; n_bad <= 0; n_aw <= 0; n_w <= 0; n_b <= 0; n_trdy <= 0;
      aw_alone <= 0; aw_wait <= 0; status_reads <= 0; dar_cyc <= 0; aw_cyc <= 0;
      last_wdata <= 32'h0; last_awaddr <= 32'h0; last_wstrb <= 4'h0;
      last_ar_status <= 1'b0; tx_consumed <= 1'b0;
      pend_ar <= 1'b0; pend_aw <= 1'b0; pend_w <= 1'b0;
      for (int i = 0; i < 8; i++) ar_cyc[i] <= 0;
    end else begin
      if ((pend_ar && !dut_arvalid) || (pend_aw && !dut_awvalid) || (pend_w && !dut_wvalid))
        viol <= viol + 1;
      pend_ar <= dut_arvalid && !rsp_arready;
      pend_aw <= dut_awvalid && !rsp_awready;
      pend_w  <= dut_wvalid && !rsp_wready;
      if (dut_arvalid && rsp_arready) begin
        last_ar_status <= (dut_araddr == 32'h1);
        if (dut_araddr == 32'h1) begin
          if (n_star < 8) ar_cyc[n_star] <= cyc;
          n_star <= n_star + 1;
        end else begin
          if (n_dar == 0) dar_cyc <= cyc;
          n_dar <= n_dar + 1;
          if (dut_araddr != 32'h0) n_bad <= n_bad + 1;
        end
      end
      if (dut_rready && rsp_rvalid && last_ar_status) status_reads <= status_reads + 1;
      if (dut_awvalid && rsp_awready) begin
        if (n_aw == 0) aw_cyc <= cyc;
        n_aw <= n_aw + 1;
        last_awaddr <= dut_awaddr;
      end
      if (dut_wvalid && rsp_wready) begin
        n_w <= n_w + 1;
        last_wdata <= dut_wdata;
        last_wstrb <= dut_wstrb;
      end
      if (dut_bready && rsp_bvalid) n_b <= n_b + 1;
      if (dut_tx_tready) n_trdy <= n_trdy + 1;
      if (dut_tx_tready && tx_tvalid) tx_consumed <= 1'b1;
      if (dut_awvalid && !dut_wvalid) aw_alone <= aw_alone + 1;
      if (dut_awvalid && !rsp_awready) aw_wait <= aw_wait + 1;
      else aw_wait <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot = n_tot + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  typedef struct {
    logic [31:0] status;
    logic [1:0]  srresp;
    logic        tx_v;
    logic [7:0]  tx_d;
    logic [7:0]  dbyte;
    logic [1:0]  drresp;
    logic [1:0]  bresp;
    int          e_wr;
    logic [31:0] e_wdata;
    int          e_rd;
    logic        e_rxv;
    logic [7:0]  e_rxd;
    logic        e_err;
    logic [1:0]  e_resp;
    int          e_trdy;
    int          e_gap;
  } vec_t;

  vec_t vecs [10];

  initial begin
    rstn = 1'b0; status_val = 32'h0; status_persist = 1'b0; status_rresp = 2'b00;
    data_byte = 8'h00; data_rresp = 2'b00; bresp_v = 2'b00; tx_valid_req = 1'b0;
    tx_tdata = 8'h00; rx_tready = 1'b0; ar_block = 1'b0; aw_lag = 0;

    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", {31'h0, any_out}, 32'h0);

    //        status         srr    txv   txd    dbyte  drr    bresp  wr wdata        rd rxv   rxd    err   resp  trdy gap
    vecs[0] = '{32'h0000_0001, 2'b00, 1'b1, 8'hA5, 8'h00, 2'b00, 2'b00, 1, 32'h0000_00A5, 0, 1'b0, 8'h00, 1'b0, 2'b00, 1, 5};
    vecs[1] = '{32'h0000_0000, 2'b00, 1'b1, 8'hA5, 8'h00, 2'b00, 2'b00, 0, 32'h0,         0, 1'b0, 8'h00, 1'b0, 2'b00, 0, 7};
    vecs[2] = '{32'h0000_0001, 2'b00, 1'b0, 8'hA5, 8'h00, 2'b00, 2'b00, 0, 32'h0,         0, 1'b0, 8'h00, 1'b0, 2'b00, 0, 7};
    vecs[3] = '{32'h0000_0010, 2'b00, 1'b0, 8'h00, 8'h3C, 2'b00, 2'b00, 0, 32'h0,         1, 1'b1, 8'h3C, 1'b0, 2'b00, 0, 5};
    vecs[4] = '{32'h0000_0011, 2'b00, 1'b1, 8'h5A, 8'h3C, 2'b00, 2'b00, 0, 32'h0,         1, 1'b1, 8'h3C, 1'b0, 2'b00, 0, 5};
    vecs[5] = '{32'h0000_0001, 2'b00, 1'b1, 8'h77, 8'h00, 2'b00, 2'b10, 1, 32'h0000_0077, 0, 1'b0, 8'h00, 1'b1, 2'b10, 1, 5};
    vecs[6] = '{32'h0000_0010, 2'b00, 1'b0, 8'h00, 8'h99, 2'b11, 2'b00, 0, 32'h0,         1, 1'b0, 8'h00, 1'b1, 2'b11, 0, 5};
    vecs[7] = '{32'h0000_0001, 2'b10, 1'b1, 8'h12, 8'h00, 2'b00, 2'b00, 0, 32'h0,         0, 1'b0, 8'h00, 1'b1, 2'b10, 0, 7};
    vecs[8] = '{32'hFFFF_FFEE, 2'b00, 1'b1, 8'hC3, 8'h00, 2'b00, 2'b00, 0, 32'h0,         0, 1'b0, 8'h00, 1'b0, 2'b00, 0, 7};
    vecs[9] = '{32'h0000_0010, 2'b00, 1'b1, 8'hD2, 8'hFF, 2'b00, 2'b00, 0, 32'h0,         1, 1'b1, 8'hFF, 1'b0, 2'b00, 0, 5};

    for (int i = 0; i < 10; i++) begin
      status_val = vecs[i].status; status_rresp = vecs[i].srresp; status_persist = 1'b0;
      tx_valid_req = vecs[i].tx_v; tx_tdata = vecs[i].tx_d; data_byte = vecs[i].dbyte;
      data_rresp = vecs[i].drresp; bresp_v = vecs[i].bresp;
      do_reset();
      repeat (30) @(negedge clk);
      chk($sformatf("v%0d_aw_count", i), n_aw, vecs[i].e_wr);
      chk($sformatf("v%0d_b_count", i), n_b, vecs[i].e_wr);
      chk($sformatf("v%0d_wdata", i), last_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d_wstrb", i), {28'h0, last_wstrb}, (vecs[i].e_wr != 0) ? 32'h1 : 32'h0);
      chk($sformatf("v%0d_awaddr", i), last_awaddr, 32'h0);
      chk($sformatf("v%0d_data_reads", i), n_dar, vecs[i].e_rd);
      chk($sformatf("v%0d_bad_araddr", i), n_bad, 0);
      chk($sformatf("v%0d_rx_tvalid", i), {31'h0, dut_rx_tvalid}, {31'h0, vecs[i].e_rxv});
      chk($sformatf("v%0d_rx_tdata", i), {24'h0, dut_rx_tdata}, {24'h0, vecs[i].e_rxd});
      chk($sformatf("v%0d_err", i), {31'h0, dut_err}, {31'h0, vecs[i].e_err});
      chk($sformatf("v%0d_err_resp", i), {30'h0, dut_err_resp}, {30'h0, vecs[i].e_resp});
      chk($sformatf("v%0d_tready_cycles", i), n_trdy, vecs[i].e_trdy);
      chk($sformatf("v%0d_poll_period", i), ar_cyc[1] - ar_cyc[0], vecs[i].e_gap);
    end
    chk("fruitless_period_2nd", ar_cyc[2] - ar_cyc[1], 7);

    // AW accepted three cycles after W: W drops, AW held, single B.
    status_val = 32'h1; status_rresp = 2'b00; tx_valid_req = 1'b1; tx_tdata = 8'h42;
    data_rresp = 2'b00; bresp_v = 2'b00; aw_lag = 3;
    do_reset();
    repeat (30) @(negedge clk);
    chk("lag_aw_count", n_aw, 1);
    chk("lag_w_count", n_w, 1);
    chk("lag_b_count", n_b, 1);
    chk("lag_aw_alone_cycles", aw_alone, 3);
    chk("lag_wdata", last_wdata, 32'h42);
    aw_lag = 0;

    // RX has priority; the pending TX byte goes out on the next poll.
    status_val = 32'h11; status_persist = 1'b1; tx_valid_req = 1'b1; tx_tdata = 8'h5A;
    data_byte = 8'h3C;
    do_reset();
    repeat (40) @(negedge clk);
    chk("prio_data_reads", n_dar, 1);
    chk("prio_writes", n_aw, 1);
    chk("prio_read_first", {31'h0, (dar_cyc < aw_cyc)}, 32'h1);
    chk("prio_rx_tdata", {24'h0, dut_rx_tdata}, 32'h3C);
    chk("prio_wdata", last_wdata, 32'h5A);
    rx_tready = 1'b1;
    @(negedge clk);
    rx_tready = 1'b0;
    chk("rx_tvalid_cleared", {31'h0, dut_rx_tvalid}, 32'h0);
    data_byte = 8'hE1;
    repeat (20) @(negedge clk);
    chk("rx_reread_count", n_dar, 2);
    chk("rx_reread_data", {24'h0, dut_rx_tdata}, 32'hE1);
    chk("no_valid_dropped", viol, 0);

    // Reset while stuck in WR clears every output on the next edge.
    status_val = 32'h1; status_persist = 1'b0; tx_valid_req = 1'b1; aw_lag = 100;
    do_reset();
    for (int k = 0; k < 20 && !dut_awvalid; k++) @(negedge clk);
    chk("midwr_awvalid_up", {31'h0, dut_awvalid}, 32'h1);
    rstn = 1'b0;
    @(negedge clk);
    chk("midwr_reset_outputs_zero", {31'h0, any_out}, 32'h0);
    aw_lag = 0;

`ifdef UART_POLLER_TIMEOUT_EN
    begin
      int high_cycles;
      ar_block = 1'b1;
      do_reset();
      for (int k = 0; k < 10 && !dut_arvalid; k++) @(negedge clk);
      high_cycles = 0;
      while (dut_arvalid && high_cycles < 40) begin
        high_cycles++;
        @(negedge clk);
      end
      chk("timeout_arvalid_cycles", high_cycles, 16);
      chk("timeout_err", {31'h0, dut_err}, 32'h1);
      chk("timeout_err_resp", {30'h0, dut_err_resp}, 32'h3);
      ar_block = 1'b0;
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
